class_argmax: RTL and testbench

- Downstream stage of the vector-matrix product.
- Takes the N per-class dot-product scores (26-bit signed each) and finds the winning class index by a sequential scan, one compare per cycle.
- Reports the winning index and its score through a start/busy/done handshake.
- Its result is the classifier's final decision for one image.

---
 rtl/class_argmax.sv | 138 +++++++++++++
 tb/tb_class_argmax.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/class_argmax.sv
// Sequential argmax over N signed scores, one compare per cycle, with start/busy/done handshake.
// Optional runner-up margin output is enabled by defining ARGMAX_MARGIN_EN.
module class_argmax #(
    parameter int unsigned N          = 10,
    parameter int unsigned SCORE_SIZE = 26,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                    clk,
    input  logic                    GlobalReset,
    input  logic                    start,
    input  logic [N*SCORE_SIZE-1:0] Scores,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        class_idx,
    output logic [SCORE_SIZE-1:0]   max_score,
    output logic [SCORE_SIZE:0]     margin
);

    localparam logic signed [SCORE_SIZE-1:0] MinScore = {1'b1, {(SCORE_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e                        state;
    logic signed [SCORE_SIZE-1:0]  bank [N];
    logic signed [SCORE_SIZE-1:0]  best;
    logic signed [SCORE_SIZE-1:0]  best_nx;
    logic signed [SCORE_SIZE-1:0]  cur;
    logic [IDX_W-1:0]              best_idx;
    logic [IDX_W-1:0]              idx_nx;
    logic [IDX_W-1:0]              ptr;
    logic                          gt;

    // Strict greater-than so ties keep the lower index.
    always_comb begin
        cur     = bank[ptr];
        gt      = cur > best;
        best_nx = gt ? cur : best;
        idx_nx  = gt ? ptr : best_idx;
    end

`ifdef ARGMAX_MARGIN_EN
    logic signed [SCORE_SIZE-1:0] second;
    logic signed [SCORE_SIZE-1:0] second_nx;
    logic [SCORE_SIZE:0]          margin_q;
    logic [SCORE_SIZE:0]          margin_scan;
    logic [SCORE_SIZE:0]          margin_one;

    always_comb begin
        second_nx   = gt ? best : ((cur > second) ? cur : second);
        margin_scan = {best_nx[SCORE_SIZE-1], best_nx} - {second_nx[SCORE_SIZE-1], second_nx};
        margin_one  = {Scores[SCORE_SIZE-1], Scores[SCORE_SIZE-1:0]}
                    - {MinScore[SCORE_SIZE-1], MinScore};
    end

    assign margin = margin_q;
`else
    assign margin = '0;
`endif

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state     <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            class_idx <= '0;
            max_score <= '0;
            best      <= '0;
            best_idx  <= '0;
            ptr       <= '0;
            for (int i = 0; i < N; i++) begin
                bank[i] <= '0;
            end
`ifdef ARGMAX_MARGIN_EN
            second    <= '0;
            margin_q  <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            bank[i] <= Scores[i*SCORE_SIZE +: SCORE_SIZE];
                        end
                        best     <= Scores[SCORE_SIZE-1:0];
                        best_idx <= '0;
                        ptr      <= IDX_W'(1);
                        busy     <= 1'b1;
`ifdef ARGMAX_MARGIN_EN
                        second   <= MinScore;
`endif
                        // A single class needs no scan; publish the result directly.
                        if (N == 1) begin
                            state     <= StDone;
                            done      <= 1'b1;
                            class_idx <= '0;
                            max_score <= Scores[SCORE_SIZE-1:0];
`ifdef ARGMAX_MARGIN_EN
                            margin_q  <= margin_one;
`endif
                        end else begin
                            state <= StScan;
                        end
                    end
                end
                StScan: begin
                    best     <= best_nx;
                    best_idx <= idx_nx;
`ifdef ARGMAX_MARGIN_EN
                    second   <= second_nx;
`endif
                    if (ptr == IDX_W'(N - 1)) begin
                        state     <= StDone;
                        done      <= 1'b1;
                        class_idx <= idx_nx;
                        max_score <= best_nx;
`ifdef ARGMAX_MARGIN_EN
                        margin_q  <= margin_scan;
`endif
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_class_argmax.sv
// Randomized + directed bench for class_argmax, checked every cycle against a behavioural model.
// Margin expectations follow ARGMAX_MARGIN_EN when it is defined for the build.
module tb_class_argmax;

    localparam int N  = 10;
    localparam int SS = 26;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            GlobalReset;
    logic            start;
    logic [N*SS-1:0] Scores;
    logic            busy;
    logic            done;
    logic [IW-1:0]   class_idx;
    logic [SS-1:0]   max_score;
    logic [SS:0]     margin;

    always #5 clk = ~clk;

    class_argmax #(.N(N), .SCORE_SIZE(SS), .IDX_W(IW)) dut (
        .clk        (clk),
        .GlobalReset(GlobalReset),
        .start      (start),
        .Scores     (Scores),
        .busy       (busy),
        .done       (done),
        .class_idx  (class_idx),
        .max_score  (max_score),
        .margin     (margin)
    );

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    int     done_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: max value, lowest index holding it, runner-up = best of the rest.
    function automatic void compute(input logic [N*SS-1:0] v, output logic [IW-1:0] ri,
                                    output logic [SS-1:0] rm, output logic [SS:0] rg);
        longint s[N];
        longint mx;
        longint sec;
        int     idx;
        for (int i = 0; i < N; i++) s[i] = longint'($signed(v[i*SS +: SS]));
        mx = s[0];
        foreach (s[i]) if (s[i] > mx) mx = s[i];
        idx = 0;
        for (int i = N - 1; i >= 0; i--) if (s[i] == mx) idx = i;
        sec = -(longint'(1) << (SS - 1));
        for (int i = 0; i < N; i++) if (i != idx && s[i] > sec) sec = s[i];
        ri = IW'(idx);
        rm = SS'(mx);
`ifdef ARGMAX_MARGIN_EN
        rg = (SS+1)'(mx - sec);
`else
        rg = '0;
`endif
    endfunction

    int            m_cnt = 0;
    bit            m_valid = 1'b0;
    logic [IW-1:0] m_idx, r_idx;
    logic [SS-1:0] m_max, r_max;
    logic [SS:0]   m_margin, r_margin;

    // Cycle-level model: a capture keeps the block busy for N cycles, last one is done.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (GlobalReset) begin
            m_cnt = 0; m_idx = '0; m_max = '0; m_margin = '0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_cnt == 0) begin
                if (start) begin
                    compute(Scores, r_idx, r_max, r_margin);
                    m_cnt = N;
                end
            end else begin
                m_cnt--;
            end
            if (m_cnt == 1) begin
                m_idx = r_idx; m_max = r_max; m_margin = r_margin;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("busy", busy, m_cnt > 0);
            chk("done", done, m_cnt == 1);
            chk("class_idx", class_idx, m_idx);
            chk("max_score", max_score, m_max);
            chk("margin", margin, m_margin);
        end
        if (done === 1'b1) done_seen++;
    end

    function automatic logic [N*SS-1:0] pack(input int a[N]);
        logic [N*SS-1:0] p;
        for (int i = 0; i < N; i++) p[i*SS +: SS] = SS'(a[i]);
        return p;
    endfunction

    task automatic launch(input logic [N*SS-1:0] v);
        @(posedge clk); #1;
        Scores = v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        bit found = 1'b0;
        cycles = 0;
        for (int k = 0; k < 3 * N && !found; k++) begin
            @(negedge clk);
            cycles++;
            if (done === 1'b1) found = 1'b1;
        end
        if (!found) chk("done_timeout", 0, 1);
    endtask

    int            basic[N] = '{5, -3, 17, 2, 17, 0, 9, -100, 16, 1};
    int            ext[N];
    int            a4[N];
    int            b7[N];
    int            c;
    int            seen0;
    longint        d1;
    logic [IW-1:0] pi;
    logic [SS-1:0] pm;
    logic [SS:0]   pg;
    logic [N*SS-1:0] rv;

    initial begin
        GlobalReset = 1'b1; start = 1'b0; Scores = '0;
        foreach (ext[i]) begin
            ext[i] = -(1 << 25); a4[i] = 0; b7[i] = i;
        end
        ext[9] = -(1 << 25) + 1; a4[4] = 1000; b7[7] = 500;

        // Pin the model itself with hand-computed results.
        compute(pack(basic), pi, pm, pg);
        chk("model_basic_idx", pi, 2);
        chk("model_basic_max", pm, 26'd17);
        compute(pack(ext), pi, pm, pg);
        chk("model_ext_idx", pi, 9);
        chk("model_ext_max", pm, 26'h2000001);

        repeat (3) @(posedge clk);
        #1 GlobalReset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_idx", class_idx, 0);
            chk("idle_max", max_score, 0);
        end

        launch(pack(basic));
        wait_done(c);
        chk("basic_latency", c, N);
        chk("basic_idx", class_idx, 2);
        chk("basic_max", max_score, 26'd17);
`ifdef ARGMAX_MARGIN_EN
        chk("basic_margin", margin, 0);
`endif

        launch(pack(ext));
        wait_done(c);
        chk("ext_idx", class_idx, 9);
        chk("ext_max", max_score, 26'h2000001);
`ifdef ARGMAX_MARGIN_EN
        chk("ext_margin", margin, 1);
`endif

        // Input change plus start while busy must not disturb the captured scan.
        launch(pack(a4));
        repeat (3) @(posedge clk);
        #1;
        a4[4] = 0; a4[0] = 5000;
        Scores = pack(a4); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(c);
        chk("busy_start_idx", class_idx, 4);
        chk("busy_start_max", max_score, 26'd1000);
        seen0 = done_seen;
        repeat (2 * N) @(negedge clk);
        chk("no_extra_done", done_seen, seen0);

        // Reset four cycles after start.
        seen0 = done_seen;
        launch(pack(basic));
        repeat (3) @(posedge clk);
        #1 GlobalReset = 1'b1;
        @(posedge clk); #1 GlobalReset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", class_idx, 0);
        chk("rst_max", max_score, 0);
        repeat (2 * N) @(negedge clk);
        chk("rst_no_done", done_seen, seen0);
        launch(pack(basic));
        wait_done(c);
        chk("after_rst_idx", class_idx, 2);

        // Back-to-back: start in the IDLE cycle right after DONE.
        d1 = cyc;
        launch(pack(b7));
        wait_done(c);
        chk("b2b_spacing", cyc - d1, N + 1);
        chk("b2b_idx", class_idx, 7);

        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 2))
                    0:       rv[i*SS +: SS] = SS'(int'($urandom_range(0, 7)) - 4);
                    1:       rv[i*SS +: SS] = SS'($urandom);
                    default: rv[i*SS +: SS] = ($urandom_range(0, 1) == 1) ?
                                              {1'b1, {(SS-1){1'b0}}} : {1'b0, {(SS-1){1'b1}}};
                endcase
            end
            launch(rv);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                Scores = SS'($urandom); start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
            wait_done(c);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
